// File: rtl/uart_pkg.sv
// Shared UART definitions: frame parser states, baud select codes,
// default framing bytes and the running checksum helper.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN,
      ST_CMD,
      ST_DATA,
      ST_CHK
   } frame_state_t;

   localparam logic [2:0] BAUD_115200 = 3'd0;
   localparam logic [2:0] BAUD_57600  = 3'd1;
   localparam logic [2:0] BAUD_38400  = 3'd2;
   localparam logic [2:0] BAUD_19200  = 3'd3;
   localparam logic [2:0] BAUD_9600   = 3'd4;

   localparam logic [7:0] DEF_HDR_BYTE = 8'hA5;
   localparam logic [7:0] DEF_CMD_BAUD = 8'h01;

   // 8-bit modulo accumulate used for the frame checksum
   function automatic logic [7:0] chk_add(input logic [7:0] sum, input logic [7:0] data);
      return sum + data;
   endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: a scratch array written by the parser and an output array
// presented to the host. A commit strobe copies scratch into output in one
// cycle, so the host view never changes while a new frame is being parsed.
// Arrays are sized to the full address range so any rd_addr returns stored data.
module uart_frame_buf #(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic          commit,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data
);

   localparam int NUM_ENT = 1 << AW;

   logic [7:0] scr_mem [NUM_ENT];
   logic [7:0] out_mem [NUM_ENT];

   // parser writes incoming payload bytes into the scratch array
   always_ff @(posedge clk) begin
      if (wr_en) begin
         scr_mem[wr_addr] <= wr_data;
      end
   end

   // output array is cleared on reset and loaded only on commit
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_ENT; i++) begin
            out_mem[i] <= 8'h00;
         end
      end else if (commit) begin
         for (int i = 0; i < NUM_ENT; i++) begin
            out_mem[i] <= scr_mem[i];
         end
      end
   end

   // host read port is combinational from the output array
   always_comb begin
      rd_data = out_mem[rd_addr];
   end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame-level controller behind the UART receiver. Parses
// HDR | LEN | CMD | payload | CHK frames, hands good packets to the host
// through a level-valid/ack handshake, and applies in-band baud changes.
// Optional inter-byte timeout: define UART_RX_FRAME_TIMEOUT_EN.
//
// state   | meaning
// --------+-------------------------------------------------
// ST_IDLE | hunting for HDR_BYTE, all other bytes dropped
// ST_LEN  | expecting length byte (1..MAX_LEN)
// ST_CMD  | expecting command byte
// ST_DATA | collecting payload bytes into scratch buffer
// ST_CHK  | expecting checksum byte, then decide fate of frame
module uart_rx_frame_ctrl
   import uart_pkg::*;
#(
   parameter int         MAX_LEN     = 16,
   parameter logic [7:0] HDR_BYTE    = DEF_HDR_BYTE,
   parameter logic [7:0] CMD_BAUD    = DEF_CMD_BAUD,
   parameter int         TIMEOUT_CYC = 50000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [7:0]                 rx_dout,
   input  logic                       rx_vld,
   output logic [2:0]                 baud_set,
   output logic                       pkt_vld,
   output logic [7:0]                 pkt_cmd,
   output logic [7:0]                 pkt_len,
   input  logic [$clog2(MAX_LEN)-1:0] rd_addr,
   output logic [7:0]                 rd_data,
   input  logic                       pkt_ack,
   output logic                       err_chk,
   output logic                       err_len,
   output logic                       err_tmo,
   output logic                       err_ovf
);

   localparam int         AW        = $clog2(MAX_LEN);
   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

   frame_state_t   state;
   logic [7:0]     len_q;
   logic [7:0]     cmd_q;
   logic [7:0]     sum_q;
   logic [7:0]     data0_q;
   logic [AW-1:0]  idx_q;

   logic           wr_en;
   logic           frame_good;
   logic           is_baud;
   logic           pkt_free;
   logic           commit;
   logic           tmo_hit;

   assign wr_en      = (state == ST_DATA) && rx_vld;
   assign frame_good = (state == ST_CHK) && rx_vld && (rx_dout == sum_q);
   assign is_baud    = (cmd_q == CMD_BAUD) && (len_q == 8'd1);
   // an ack landing in the commit cycle releases the old packet first
   assign pkt_free   = !pkt_vld || pkt_ack;
   assign commit     = frame_good && !is_baud && pkt_free;

`ifdef UART_RX_FRAME_TIMEOUT_EN
   localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CYC - 1);

   logic [15:0] tmo_cnt;

   // inter-byte timer: reload on every byte, count down while inside a frame
   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt <= TMO_LOAD;
      end else if (rx_vld) begin
         tmo_cnt <= TMO_LOAD;
      end else if ((state != ST_IDLE) && (tmo_cnt != 16'd0)) begin
         tmo_cnt <= tmo_cnt - 16'd1;
      end
   end

   assign tmo_hit = (state != ST_IDLE) && !rx_vld && (tmo_cnt == 16'd0);

   // timeout error is a one-cycle pulse aligned with the abort
   always_ff @(posedge clk) begin
      if (rst) begin
         err_tmo <= 1'b0;
      end else begin
         err_tmo <= tmo_hit;
      end
   end
`else
   assign tmo_hit = 1'b0;
   assign err_tmo = 1'b0;
`endif

   // frame parser with registered host outputs and error pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         len_q    <= 8'h00;
         cmd_q    <= 8'h00;
         sum_q    <= 8'h00;
         data0_q  <= 8'h00;
         idx_q    <= '0;
         baud_set <= BAUD_115200;
         pkt_vld  <= 1'b0;
         pkt_cmd  <= 8'h00;
         pkt_len  <= 8'h00;
         err_chk  <= 1'b0;
         err_len  <= 1'b0;
         err_ovf  <= 1'b0;
      end else begin
         err_chk <= 1'b0;
         err_len <= 1'b0;
         err_ovf <= 1'b0;

         if (pkt_ack && pkt_vld) begin
            pkt_vld <= 1'b0;
         end

         if (tmo_hit) begin
            state <= ST_IDLE;
         end else if (rx_vld) begin
            case (state)
               ST_IDLE: begin
                  if (rx_dout == HDR_BYTE) begin
                     state <= ST_LEN;
                  end
               end
               ST_LEN: begin
                  if ((rx_dout != 8'h00) && (rx_dout <= MAX_LEN_B)) begin
                     len_q <= rx_dout;
                     sum_q <= rx_dout;
                     idx_q <= '0;
                     state <= ST_CMD;
                  end else begin
                     err_len <= 1'b1;
                     state   <= ST_IDLE;
                  end
               end
               ST_CMD: begin
                  cmd_q <= rx_dout;
                  sum_q <= chk_add(sum_q, rx_dout);
                  state <= ST_DATA;
               end
               ST_DATA: begin
                  sum_q <= chk_add(sum_q, rx_dout);
                  if (idx_q == '0) begin
                     data0_q <= rx_dout;
                  end
                  if (8'(idx_q) == (len_q - 8'd1)) begin
                     state <= ST_CHK;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
               ST_CHK: begin
                  state <= ST_IDLE;
                  if (!frame_good) begin
                     err_chk <= 1'b1;
                  end else if (is_baud) begin
                     if (data0_q <= {5'd0, BAUD_9600}) begin
                        baud_set <= data0_q[2:0];
                     end else begin
                        err_len <= 1'b1;
                     end
                  end else if (pkt_free) begin
                     pkt_vld <= 1'b1;
                     pkt_cmd <= cmd_q;
                     pkt_len <= len_q;
                  end else begin
                     err_ovf <= 1'b1;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   uart_frame_buf #(
      .DEPTH (MAX_LEN),
      .AW    (AW)
   ) u_frame_buf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_addr (idx_q),
      .wr_data (rx_dout),
      .commit  (commit),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

endmodule
